icache_refill_ctrl: RTL and testbench

Instruction-cache miss handler: the initiator side of the main-memory read interface (`Access_MM` / address / `Data_MM`). On a cache miss it fetches a full block from main memory one word at a time, with a programmable per-word wait. It delivers each word to the cache line write port and signals completion. It sits between the instruction cache's miss logic and main memory.

---
 rtl/mm_pkg.sv | 19 +
 rtl/refill_wait_cnt.sv | 22 ++
 rtl/icache_refill_ctrl.sv | 103 ++++++++++
 tb/tb_icache_refill_ctrl.sv | 240 ++++++++++++++++++++++++
 4 files changed

// File: rtl/mm_pkg.sv
// Shared definitions for the main-memory read initiator: FSM states, word size,
// default block geometry and refill counter width.
package mm_pkg;
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DONE  = 2'd2
  } mm_state_t;

  localparam int WORD_BYTES          = 4;
  localparam int DEF_WORDS_PER_BLOCK = 4;
  localparam int DEF_MM_LATENCY      = 2;
  localparam int REFILL_CNT_W        = 16;

  // Clear the in-block offset bits of a byte address.
  function automatic logic [31:0] blk_align(input logic [31:0] a, input int blk_bytes);
    return a & ~(32'(blk_bytes) - 32'd1);
  endfunction
endpackage

// File: rtl/refill_wait_cnt.sv
// Per-word wait counter: counts 0..MOD-1 while enabled, load clears it,
// tc flags the last wait cycle of a word.
module refill_wait_cnt #(
  parameter  int MOD = 2,
  localparam int CW  = (MOD > 1) ? $clog2(MOD) : 1
) (
  input  logic CLK,
  input  logic RESET_N,
  input  logic load,
  input  logic en,
  output logic tc
);
  logic [CW-1:0] cnt_q;

  assign tc = (cnt_q == CW'(MOD - 1));

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)  cnt_q <= '0;
    else if (load) cnt_q <= '0;
    else if (en)   cnt_q <= tc ? '0 : cnt_q + 1'b1;
  end
endmodule

// File: rtl/icache_refill_ctrl.sv
// I-cache miss handler: fetches one block from main memory word by word with a
// fixed per-word wait, writes each word into the line and pulses completion.
module icache_refill_ctrl
  import mm_pkg::*;
#(
  parameter  int WORDS_PER_BLOCK = DEF_WORDS_PER_BLOCK,
  parameter  int MM_LATENCY      = DEF_MM_LATENCY,
  localparam int WW              = $clog2(WORDS_PER_BLOCK)
) (
  input  logic                    CLK,
  input  logic                    RESET_N,
  input  logic                    Miss_Req,
  input  logic [31:0]             Miss_Addr,
  output logic                    Access_MM,
  output logic [31:0]             PC_MM,
  input  logic [31:0]             Data_MM,
  output logic                    Line_We,
  output logic [WW-1:0]           Line_Word,
  output logic [31:0]             Line_Data,
  output logic [31:0]             Line_Addr,
  output logic                    Refill_Done,
  output logic                    Busy,
  output logic [REFILL_CNT_W-1:0] Refill_Cnt
);
  localparam int BLK_BYTES = WORDS_PER_BLOCK * WORD_BYTES;

  mm_state_t     state_q, state_d;
  logic [WW-1:0] word_q;
  logic          wait_tc;
  logic          word_last;
  logic          word_end;

  assign word_last = (word_q == WW'(WORDS_PER_BLOCK - 1));
  assign word_end  = (state_q == FETCH) && wait_tc;
  assign Busy      = (state_q != IDLE);

  refill_wait_cnt #(.MOD(MM_LATENCY)) u_wait (
    .CLK     (CLK),
    .RESET_N (RESET_N),
    .load    (state_q == IDLE),
    .en      (state_q == FETCH),
    .tc      (wait_tc)
  );

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) state_q <= IDLE;
    else          state_q <= state_d;
  end

  always_comb begin
    state_d     = state_q;
    Access_MM   = 1'b0;
    Refill_Done = 1'b0;
    PC_MM       = '0;
    case (state_q)
      IDLE:  if (Miss_Req) state_d = FETCH;
      FETCH: begin
        Access_MM = 1'b1;
        PC_MM     = Line_Addr + 32'(word_q) * 32'(WORD_BYTES);
        if (wait_tc && word_last) state_d = DONE;
      end
      DONE: begin
        Refill_Done = 1'b1;
        state_d     = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // Word index only advances on the last wait cycle; it wraps to 0 at block end.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      word_q    <= '0;
      Line_Addr <= '0;
    end else if (state_q == IDLE) begin
      word_q <= '0;
      if (Miss_Req) Line_Addr <= blk_align(Miss_Addr, BLK_BYTES);
    end else if (word_end) begin
      word_q <= word_q + 1'b1;
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      Line_We   <= 1'b0;
      Line_Word <= '0;
      Line_Data <= '0;
    end else begin
      Line_We <= word_end;
      if (word_end) begin
        Line_Word <= word_q;
        Line_Data <= Data_MM;
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N)
      Refill_Cnt <= '0;
    else if (state_q == DONE && Refill_Cnt != '1)
      Refill_Cnt <= Refill_Cnt + 1'b1;
  end
endmodule

// File: tb/tb_icache_refill_ctrl.sv
// Bench for icache_refill_ctrl: cycle-by-cycle comparison against a timeline
// computed from accept-relative cycle numbers, with a hashed memory image.
module tb_icache_refill_ctrl;
  localparam int W  = 4;
  localparam int L  = 2;
  localparam int L1 = 1;
  localparam int N  = W * L;

  logic        CLK = 1'b0;
  logic        RESET_N = 1'b1;
  always #5 CLK = ~CLK;

  logic        miss_req, access, we, done, busy;
  logic [31:0] miss_addr, pc, data_mm, ldata, laddr;
  logic [1:0]  word;
  logic [15:0] cnt;

  logic        miss_req1, access1, we1, done1, busy1;
  logic [31:0] miss_addr1, pc1, data_mm1, ldata1, laddr1;
  logic [1:0]  word1;
  logic [15:0] cnt1;

  int          checks = 0;
  int          errors = 0;
  logic [31:0] salt = 32'h1234_5678;
  logic [15:0] exp_cnt = '0;
  logic [1:0]  last_word = '0;
  logic [31:0] last_data = '0;

  function automatic logic [31:0] memf(input logic [31:0] a, input logic [31:0] s);
    return (a * 32'h9E37_79B1) ^ s;
  endfunction

  assign data_mm  = memf(pc, salt);
  assign data_mm1 = memf(pc1, salt);

  icache_refill_ctrl #(.WORDS_PER_BLOCK(W), .MM_LATENCY(L)) dut (
    .CLK(CLK), .RESET_N(RESET_N), .Miss_Req(miss_req), .Miss_Addr(miss_addr),
    .Access_MM(access), .PC_MM(pc), .Data_MM(data_mm), .Line_We(we),
    .Line_Word(word), .Line_Data(ldata), .Line_Addr(laddr),
    .Refill_Done(done), .Busy(busy), .Refill_Cnt(cnt)
  );

  icache_refill_ctrl #(.WORDS_PER_BLOCK(W), .MM_LATENCY(L1)) dut1 (
    .CLK(CLK), .RESET_N(RESET_N), .Miss_Req(miss_req1), .Miss_Addr(miss_addr1),
    .Access_MM(access1), .PC_MM(pc1), .Data_MM(data_mm1), .Line_We(we1),
    .Line_Word(word1), .Line_Data(ldata1), .Line_Addr(laddr1),
    .Refill_Done(done1), .Busy(busy1), .Refill_Cnt(cnt1)
  );

  // One refill on dut; expectations come from cycle number c after the accept.
  task automatic do_refill(input logic [31:0] addr, input bit keep, input bit mangle);
    logic [31:0] line, exp_pc;
    logic        exp_acc, exp_we, exp_done;
    int          k;
    line = addr - (addr % (W * 4));
    @(negedge CLK);
    checks++;
    if (busy !== 1'b0 || cnt !== exp_cnt) begin
      errors++;
      $display("FAIL pre_idle busy=%b cnt=%h expected busy=0 cnt=%h", busy, cnt, exp_cnt);
    end
    miss_req = 1'b1; miss_addr = addr;
    @(posedge CLK);
    for (int c = 1; c <= N + 1; c++) begin
      @(negedge CLK);
      exp_acc  = (c <= N);
      exp_pc   = exp_acc ? line + 32'(4 * ((c - 1) / L)) : 32'h0;
      exp_we   = (c >= L + 1) && ((c - 1) % L == 0);
      exp_done = (c == N + 1);
      if (exp_we) begin
        k = (c - 1) / L - 1;
        last_word = 2'(k);
        last_data = memf(line + 32'(4 * k), salt);
      end
      checks++;
      if ({access, we, done, busy} !== {exp_acc, exp_we, exp_done, 1'b1}) begin
        errors++;
        $display("FAIL ctrl c=%0d acc/we/done/busy=%b%b%b%b expected %b%b%b1",
                 c, access, we, done, busy, exp_acc, exp_we, exp_done);
      end
      checks++;
      if (pc !== exp_pc) begin
        errors++; $display("FAIL pc_mm c=%0d got %h expected %h", c, pc, exp_pc);
      end
      checks++;
      if (laddr !== line) begin
        errors++; $display("FAIL line_addr c=%0d got %h expected %h", c, laddr, line);
      end
      checks++;
      if (word !== last_word || ldata !== last_data) begin
        errors++;
        $display("FAIL line_port c=%0d word=%0d data=%h expected word=%0d data=%h",
                 c, word, ldata, last_word, last_data);
      end
      if (!keep && c == 1) miss_req = 1'b0;
      if (mangle && c == 3) begin miss_req = 1'b0; miss_addr = 32'h40; end
    end
    exp_cnt = (exp_cnt == 16'hFFFF) ? exp_cnt : exp_cnt + 16'd1;
  endtask

  task automatic check_idle(input string tag);
    @(negedge CLK);
    checks++;
    if ({busy, access, done, we} !== 4'b0 || pc !== 32'h0 || cnt !== exp_cnt) begin
      errors++;
      $display("FAIL %s busy/acc/done/we=%b%b%b%b pc=%h cnt=%h expected 0000 pc=0 cnt=%h",
               tag, busy, access, done, we, pc, cnt, exp_cnt);
    end
  endtask

  task automatic test_reset();
    miss_req = 1'($urandom); miss_addr = $urandom;
    miss_req1 = 1'($urandom); miss_addr1 = $urandom;
    #3 RESET_N = 1'b0;
    #1;
    checks++;
    if ({access, we, done, busy} !== 4'b0 || pc !== 0 || word !== 0 || ldata !== 0 ||
        laddr !== 0 || cnt !== 0) begin
      errors++;
      $display("FAIL reset_vals acc/we/done/busy=%b%b%b%b pc=%h word=%0d data=%h addr=%h cnt=%h expected all 0",
               access, we, done, busy, pc, word, ldata, laddr, cnt);
    end
    checks++;
    if ({access1, we1, done1, busy1} !== 4'b0 || cnt1 !== 0 || laddr1 !== 0) begin
      errors++;
      $display("FAIL reset_vals1 acc/we/done/busy=%b%b%b%b cnt=%h expected all 0",
               access1, we1, done1, busy1, cnt1);
    end
    @(negedge CLK);
    miss_req = 1'b0; miss_req1 = 1'b0;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 3; i++) check_idle("reset_idle");
  endtask

  task automatic test_basic();
    salt = $urandom;
    do_refill(32'h0000_0014, 1'b0, 1'b0);
    check_idle("basic_end");
    for (int i = 0; i < 3; i++) begin
      salt = $urandom;
      do_refill($urandom, 1'b0, 1'b0);
    end
    check_idle("basic_rand_end");
  endtask

  task automatic test_ignored_inputs();
    do_refill(32'h0000_0014, 1'b1, 1'b1);
    check_idle("ignored_end");
  endtask

  task automatic test_latency1();
    logic [31:0] addr, line;
    logic        e_acc, e_we, e_done, e_busy;
    addr = $urandom; line = addr - (addr % (W * 4));
    @(negedge CLK);
    miss_req1 = 1'b1; miss_addr1 = addr;
    @(posedge CLK);
    for (int c = 1; c <= W + 2; c++) begin
      @(negedge CLK);
      e_acc = (c <= W); e_done = (c == W + 1); e_busy = (c <= W + 1);
      e_we = (c >= 2) && (c <= W + 1);
      checks++;
      if ({access1, we1, done1, busy1} !== {e_acc, e_we, e_done, e_busy}) begin
        errors++;
        $display("FAIL lat1_ctrl c=%0d acc/we/done/busy=%b%b%b%b expected %b%b%b%b",
                 c, access1, we1, done1, busy1, e_acc, e_we, e_done, e_busy);
      end
      if (e_we) begin
        checks++;
        if (word1 !== 2'(c - 2) || ldata1 !== memf(line + 32'(4 * (c - 2)), salt)) begin
          errors++;
          $display("FAIL lat1_word c=%0d word=%0d data=%h expected word=%0d data=%h",
                   c, word1, ldata1, c - 2, memf(line + 32'(4 * (c - 2)), salt));
        end
      end
      miss_req1 = 1'b0;
    end
    checks++;
    if (cnt1 !== 16'd1) begin
      errors++; $display("FAIL lat1_cnt got %h expected 0001", cnt1);
    end
  endtask

  task automatic test_reset_mid();
    @(negedge CLK);
    miss_req = 1'b1; miss_addr = $urandom;
    @(posedge CLK);
    for (int c = 1; c <= 4; c++) begin
      @(negedge CLK);
      miss_req = 1'b0;
    end
    #2 RESET_N = 1'b0;
    #1;
    checks++;
    if ({access, we, done, busy} !== 4'b0 || pc !== 0 || cnt !== 0) begin
      errors++;
      $display("FAIL reset_mid acc/we/done/busy=%b%b%b%b pc=%h cnt=%h expected all 0",
               access, we, done, busy, pc, cnt);
    end
    exp_cnt = '0; last_word = '0; last_data = '0;
    @(negedge CLK);
    RESET_N = 1'b1;
    for (int i = 0; i < 4; i++) check_idle("reset_mid_idle");
    do_refill($urandom, 1'b0, 1'b0);
    check_idle("reset_mid_refill");
  endtask

  task automatic test_back_to_back();
    do_refill($urandom, 1'b1, 1'b0);
    do_refill($urandom, 1'b1, 1'b0);
    do_refill($urandom, 1'b0, 1'b0);
    check_idle("b2b_end");
  endtask

  task automatic test_saturation();
    @(negedge CLK);
    force dut.Refill_Cnt = 16'hFFFE;
    @(posedge CLK);
    #1 release dut.Refill_Cnt;
    exp_cnt = 16'hFFFE;
    do_refill($urandom, 1'b0, 1'b0);
    check_idle("sat_first");
    do_refill($urandom, 1'b0, 1'b0);
    check_idle("sat_second");
  endtask

  initial begin
    test_reset();
    test_basic();
    test_ignored_inputs();
    test_latency1();
    test_reset_mid();
    test_back_to_back();
    test_saturation();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
